regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port between three requesters: pipeline writeback (WB), the multi-cycle multiply/divide unit (MDU), and the debug port (DBG).
- Keeps a per-register pending-write scoreboard for in-flight MDU destinations, so the hazard unit can stall dependent reads.
- Forces a WB bubble when the MDU has been starved too long.
- Sits between the WB stage, the MDU, the debug module and the 32x32 register file write port.

Parameters:
- REG_COUNT, 32, number of architectural registers.
- REG_ADDR_WIDTH, 5, register address width.
- XLEN, 32, data width.
- STARVE_LIMIT, 4, consecutive blocked MDU cycles before hold_wb asserts (range 1..15).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- wb_we  in  1  WB write request; no backpressure
- wb_rd  in  REG_ADDR_WIDTH  WB destination
- wb_data  in  XLEN  WB data
- hold_wb  out  1  registered; pipeline must present wb_we=0 while high
- mdu_issue  in  1  MDU op issued this cycle
- mdu_issue_rd  in  REG_ADDR_WIDTH  destination of the issued op
- mdu_valid  in  1  MDU result available
- mdu_rd  in  REG_ADDR_WIDTH  MDU result destination
- mdu_data  in  XLEN  MDU result data
- mdu_ready  out  1  MDU result accepted this cycle
- dbg_valid  in  1  debug write request
- dbg_rd  in  REG_ADDR_WIDTH  debug destination
- dbg_data  in  XLEN  debug data
- dbg_ready  out  1  debug write accepted this cycle
- rs_addr  in  REG_ADDR_WIDTH  decode read address A
- rt_addr  in  REG_ADDR_WIDTH  decode read address B
- rs_busy  out  1  rs_addr has a pending MDU write
- rt_busy  out  1  rt_addr has a pending MDU write
- rf_we  out  1  register file write enable
- rf_rd  out  REG_ADDR_WIDTH  register file write address
- rf_data  out  XLEN  register file write data

Behaviour:
- Reset (async): scoreboard cleared, wait_cnt=0, hold_wb=0. While reset is high, rf_we, mdu_ready, dbg_ready, rs_busy and rt_busy are all 0.
- Arbitration is combinational and has zero latency: the grant and rf_* outputs appear in the same cycle as the request.
- wb_active = wb_we && wb_rd!=0. WB writes to $zero never occupy the port.
- Priority is WB > MDU > DBG:
  - mdu_ready = mdu_valid && !wb_active.
  - dbg_ready = dbg_valid && !wb_active && !mdu_valid.
- rf_* carries the winning requester's rd/data.
- rf_we = 1 only when a winner exists and its rd!=0.
- A request to rd=0 is still handshaken (ready=1) but produces rf_we=0.
- When no requester wins: rf_we=0, rf_rd=0, rf_data=0.
- MDU and DBG hold rd/data stable while valid && !ready; the block does not buffer requests.
- Scoreboard: busy[REG_COUNT-1:0], bit 0 is constant 0.
  - On a clock edge, mdu_issue with mdu_issue_rd!=0 sets busy[mdu_issue_rd].
  - A clock edge with mdu_valid && mdu_ready clears busy[mdu_rd].
  - Same register set and cleared on the same edge: set wins.
- rs_busy = busy[rs_addr] and rt_busy = busy[rt_addr], combinational. The ports do not forward the current-cycle issue.
- Issuing to an already-busy register is illegal: the hazard unit prevents it, the bit simply stays set, and the bench flags it with an assertion.
- Starvation control (wait_cnt is 4 bits):
  - On each edge with mdu_valid && !mdu_ready, wait_cnt increments, saturating at STARVE_LIMIT.
  - An edge with an MDU handshake or with mdu_valid=0 sets wait_cnt to 0.
  - hold_wb is set on the edge where a blocked cycle brings wait_cnt to STARVE_LIMIT.
  - hold_wb is cleared on the edge of an MDU handshake, or when mdu_valid is 0.
- If wb_active occurs while hold_wb=1, that is a protocol violation: WB still wins, the hold stays asserted, and the bench asserts on it.
- Reset mid-operation clears all pending bits. In-flight MDU results after reset are accepted normally and clearing an already-clear bit is harmless.
- Debug has no starvation guarantee; it is used only while the core is halted.

Test Plan:
- Reset, then idle with all requests low -> rf_we=0, mdu_ready=0, dbg_ready=0, hold_wb=0, rs_busy=rt_busy=0.
- Same cycle wb_we=1/rd=3/data=0xAAAA0001, mdu_valid rd=5, dbg_valid rd=7 -> rf rd=3 data 0xAAAA0001, mdu_ready=0. Next cycle with WB idle -> MDU rd=5 granted. Following cycle -> DBG rd=7 granted.
- Issue the MDU op as mdu_issue with rd=9 -> rs_addr=9 shows rs_busy=1 next cycle. The result rd=9 handshake on a WB-idle cycle -> rf_we rd=9, and rs_busy=0 the cycle after. In the same-edge case, an issue rd=9 coinciding with a completion rd=9 -> busy[9] stays 1.
- wb_we=1 to nonzero rd every cycle with mdu_valid held, STARVE_LIMIT=4 -> hold_wb=1 after the 4th blocked cycle. The bench then drops wb_we -> mdu_ready=1 that cycle, and hold_wb=0 next cycle.
- wb_we=1 with wb_rd=0 alongside mdu_valid rd=4 -> MDU granted with rf_we=1/rf_rd=4. Separately, dbg_valid to rd=0 -> dbg_ready=1 and rf_we=0.
- Pending bits set on regs 2, 6 and 31, then reset asserted mid-cycle -> all busy outputs 0 immediately, and hold_wb=0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: WB > MDU > DBG, with a pending-write
// scoreboard for in-flight MDU destinations and an MDU anti-starvation hold.
module regfile_write_arbiter #(
  parameter int REG_COUNT      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int XLEN           = 32,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wb_we,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic [XLEN-1:0]           wb_data,
  output logic                      hold_wb,
  input  logic                      mdu_issue,
  input  logic [REG_ADDR_WIDTH-1:0] mdu_issue_rd,
  input  logic                      mdu_valid,
  input  logic [REG_ADDR_WIDTH-1:0] mdu_rd,
  input  logic [XLEN-1:0]           mdu_data,
  output logic                      mdu_ready,
  input  logic                      dbg_valid,
  input  logic [REG_ADDR_WIDTH-1:0] dbg_rd,
  input  logic [XLEN-1:0]           dbg_data,
  output logic                      dbg_ready,
  input  logic [REG_ADDR_WIDTH-1:0] rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rt_addr,
  output logic                      rs_busy,
  output logic                      rt_busy,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_rd,
  output logic [XLEN-1:0]           rf_data
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [REG_COUNT-1:0] busy_q, busy_d;
  logic [3:0]           wait_cnt_q, wait_cnt_d;
  logic                 hold_wb_q, hold_wb_d;

  logic wb_active;
  logic mdu_hs;

  assign wb_active = wb_we && (wb_rd != '0);

  // Handshakes are masked during reset so nothing is accepted while it is held.
  assign mdu_ready = !reset && mdu_valid && !wb_active;
  assign dbg_ready = !reset && dbg_valid && !wb_active && !mdu_valid;
  assign mdu_hs    = mdu_valid && mdu_ready;

  always_comb begin
    rf_we   = 1'b0;
    rf_rd   = '0;
    rf_data = '0;
    if (!reset) begin
      if (wb_active) begin
        rf_we   = 1'b1;
        rf_rd   = wb_rd;
        rf_data = wb_data;
      end else if (mdu_valid) begin
        rf_we   = (mdu_rd != '0);
        rf_rd   = mdu_rd;
        rf_data = mdu_data;
      end else if (dbg_valid) begin
        rf_we   = (dbg_rd != '0);
        rf_rd   = dbg_rd;
        rf_data = dbg_data;
      end
    end
  end

  // Per-register scoreboard update; a same-edge issue wins over a completion.
  assign busy_d[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < REG_COUNT; gi++) begin : g_busy
      logic set_b, clr_b;
      assign set_b      = mdu_issue && (mdu_issue_rd == REG_ADDR_WIDTH'(gi));
      assign clr_b      = mdu_hs && (mdu_rd == REG_ADDR_WIDTH'(gi));
      assign busy_d[gi] = set_b || (busy_q[gi] && !clr_b);
    end
  endgenerate

  always_comb begin
    wait_cnt_d = 4'd0;
    hold_wb_d  = 1'b0;
    if (mdu_valid && !mdu_ready) begin
      wait_cnt_d = (wait_cnt_q >= LIMIT) ? LIMIT : wait_cnt_q + 4'd1;
      hold_wb_d  = hold_wb_q || (wait_cnt_d == LIMIT);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q     <= '0;
      wait_cnt_q <= 4'd0;
      hold_wb_q  <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      wait_cnt_q <= wait_cnt_d;
      hold_wb_q  <= hold_wb_d;
    end
  end

  assign hold_wb = hold_wb_q;
  assign rs_busy = !reset && busy_q[rs_addr];
  assign rt_busy = !reset && busy_q[rt_addr];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: arbitration, scoreboard,
// starvation hold and mid-cycle reset, plus protocol monitors.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        hold_wb;
  logic        mdu_issue = 1'b0;
  logic [4:0]  mdu_issue_rd = '0;
  logic        mdu_valid = 1'b0;
  logic [4:0]  mdu_rd = '0;
  logic [31:0] mdu_data = '0;
  logic        mdu_ready;
  logic        dbg_valid = 1'b0;
  logic [4:0]  dbg_rd = '0;
  logic [31:0] dbg_data = '0;
  logic        dbg_ready;
  logic [4:0]  rs_addr = '0;
  logic [4:0]  rt_addr = '0;
  logic        rs_busy, rt_busy;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .REG_COUNT(32), .REG_ADDR_WIDTH(5), .XLEN(32), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .hold_wb(hold_wb),
    .mdu_issue(mdu_issue), .mdu_issue_rd(mdu_issue_rd),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .dbg_valid(dbg_valid), .dbg_rd(dbg_rd), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bench-side pending model, driven purely from stimulus, for the illegal-issue monitor.
  logic [31:0] pend;
  logic        wb_act_m, mdu_hs_m;
  assign wb_act_m = wb_we && (wb_rd != 5'd0);
  assign mdu_hs_m = mdu_valid && !wb_act_m;

  always @(posedge clk or posedge reset) begin
    if (reset) pend <= '0;
    else begin
      if (mdu_hs_m) pend[mdu_rd] <= 1'b0;
      if (mdu_issue && mdu_issue_rd != 5'd0) pend[mdu_issue_rd] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      total++;
      assert (!(wb_act_m && hold_wb)) else begin
        bad++;
        $error("FAIL wb_during_hold observed=%0d expected=0", wb_act_m && hold_wb);
      end
      total++;
      assert (!(mdu_issue && mdu_issue_rd != 5'd0 && pend[mdu_issue_rd] &&
                !(mdu_hs_m && mdu_rd == mdu_issue_rd))) else begin
        bad++;
        $error("FAIL issue_to_busy observed=rd%0d expected=free", mdu_issue_rd);
      end
    end
  end

  initial begin
    // Requests present while reset is held must not be granted.
    mdu_valid = 1'b1; mdu_rd = 5'd5; dbg_valid = 1'b1; dbg_rd = 5'd7;
    #2;
    $display("txn: reset held with requests");
    chk("rst_mdu_ready", mdu_ready, 0);
    chk("rst_dbg_ready", dbg_ready, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_hold", hold_wb, 0);
    chk("rst_rs_busy", rs_busy, 0);
    mdu_valid = 1'b0; dbg_valid = 1'b0;

    tick(); reset = 1'b0; #1;
    $display("txn: idle");
    chk("idle_rf_we", rf_we, 0);
    chk("idle_rf_rd", rf_rd, 0);
    chk("idle_rf_data", rf_data, 0);
    chk("idle_mdu_ready", mdu_ready, 0);
    chk("idle_dbg_ready", dbg_ready, 0);
    chk("idle_hold", hold_wb, 0);
    chk("idle_rt_busy", rt_busy, 0);

    tick();
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hAAAA0001;
    mdu_valid = 1'b1; mdu_rd = 5'd5; mdu_data = 32'h5555_0005;
    dbg_valid = 1'b1; dbg_rd = 5'd7; dbg_data = 32'h7777_0007;
    #1;
    $display("txn: three-way contention, WB wins");
    chk("prio_wb_rf_we", rf_we, 1);
    chk("prio_wb_rf_rd", rf_rd, 3);
    chk("prio_wb_rf_data", rf_data, 32'hAAAA0001);
    chk("prio_wb_mdu_ready", mdu_ready, 0);
    chk("prio_wb_dbg_ready", dbg_ready, 0);

    tick(); wb_we = 1'b0; #1;
    $display("txn: MDU wins over DBG");
    chk("prio_mdu_ready", mdu_ready, 1);
    chk("prio_mdu_rf_rd", rf_rd, 5);
    chk("prio_mdu_rf_data", rf_data, 32'h5555_0005);
    chk("prio_mdu_dbg_ready", dbg_ready, 0);

    tick(); mdu_valid = 1'b0; #1;
    $display("txn: DBG granted");
    chk("prio_dbg_ready", dbg_ready, 1);
    chk("prio_dbg_rf_we", rf_we, 1);
    chk("prio_dbg_rf_rd", rf_rd, 7);
    chk("prio_dbg_rf_data", rf_data, 32'h7777_0007);

    tick(); dbg_valid = 1'b0; mdu_issue = 1'b1; mdu_issue_rd = 5'd9; rs_addr = 5'd9; rt_addr = 5'd9; #1;
    $display("txn: issue rd9");
    chk("issue_no_fwd", rs_busy, 0);

    tick(); mdu_issue = 1'b0; #1;
    $display("txn: rd9 pending");
    chk("sb_rs_busy9", rs_busy, 1);
    chk("sb_rt_busy9", rt_busy, 1);

    tick(); mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h0000_0099; #1;
    $display("txn: rd9 result");
    chk("sb_done_ready", mdu_ready, 1);
    chk("sb_done_rf_we", rf_we, 1);
    chk("sb_done_rf_rd", rf_rd, 9);
    chk("sb_done_still_busy", rs_busy, 1);

    tick(); mdu_valid = 1'b0; #1;
    chk("sb_cleared9", rs_busy, 0);

    tick(); mdu_issue = 1'b1; mdu_issue_rd = 5'd9; #1;
    tick(); mdu_valid = 1'b1; mdu_rd = 5'd9; #1;
    $display("txn: reissue rd9 on completion edge");
    chk("same_edge_ready", mdu_ready, 1);
    tick(); mdu_issue = 1'b0; mdu_valid = 1'b0; #1;
    chk("same_edge_set_wins", rs_busy, 1);
    tick(); mdu_valid = 1'b1; #1;
    tick(); mdu_valid = 1'b0; #1;
    chk("same_edge_final_clear", rs_busy, 0);

    tick(); wb_we = 1'b1; wb_rd = 5'd10; mdu_valid = 1'b1; mdu_rd = 5'd11; mdu_data = 32'h0000_00BB; #1;
    $display("txn: MDU starved by WB");
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 4) wb_we = 1'b0;
      #1;
      chk($sformatf("starve_hold_%0d", i), hold_wb, (i == 4) ? 1 : 0);
    end
    chk("starve_release_ready", mdu_ready, 1);
    chk("starve_release_rf_rd", rf_rd, 11);
    tick(); mdu_valid = 1'b0; #1;
    chk("starve_hold_cleared", hold_wb, 0);

    tick(); wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD_0000;
    mdu_valid = 1'b1; mdu_rd = 5'd4; mdu_data = 32'h0000_0044; #1;
    $display("txn: WB to r0 alongside MDU rd4");
    chk("wb_zero_mdu_ready", mdu_ready, 1);
    chk("wb_zero_rf_we", rf_we, 1);
    chk("wb_zero_rf_rd", rf_rd, 4);
    chk("wb_zero_rf_data", rf_data, 32'h0000_0044);

    tick(); wb_we = 1'b0; mdu_valid = 1'b0; dbg_valid = 1'b1; dbg_rd = 5'd0; dbg_data = 32'h1234; #1;
    $display("txn: DBG to r0");
    chk("dbg_zero_ready", dbg_ready, 1);
    chk("dbg_zero_rf_we", rf_we, 0);

    tick(); dbg_valid = 1'b0; mdu_issue = 1'b1; mdu_issue_rd = 5'd2; #1;
    tick(); mdu_issue_rd = 5'd6; #1;
    tick(); mdu_issue_rd = 5'd31; #1;
    tick(); mdu_issue = 1'b0; rs_addr = 5'd2; rt_addr = 5'd31; #1;
    $display("txn: pending 2,6,31");
    chk("pend_rs2", rs_busy, 1);
    chk("pend_rt31", rt_busy, 1);
    rs_addr = 5'd6; rt_addr = 5'd0; #1;
    chk("pend_rs6", rs_busy, 1);
    chk("pend_rt0", rt_busy, 0);

    wb_we = 1'b1; wb_rd = 5'd12; mdu_valid = 1'b1; mdu_rd = 5'd13; mdu_data = 32'h0000_00DD;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 4) wb_we = 1'b0;
    end
    #1;
    chk("pre_reset_hold", hold_wb, 1);
    rs_addr = 5'd2; rt_addr = 5'd31;
    reset = 1'b1; #1;
    $display("txn: reset mid-cycle");
    chk("midrst_rs_busy", rs_busy, 0);
    chk("midrst_rt_busy", rt_busy, 0);
    chk("midrst_hold", hold_wb, 0);
    chk("midrst_mdu_ready", mdu_ready, 0);
    chk("midrst_rf_we", rf_we, 0);

    tick(); reset = 1'b0; #1;
    $display("txn: in-flight MDU after reset");
    chk("post_rst_ready", mdu_ready, 1);
    chk("post_rst_rf_rd", rf_rd, 13);
    chk("post_rst_rs2", rs_busy, 0);
    tick(); mdu_valid = 1'b0; rs_addr = 5'd6; #1;
    chk("post_rst_rs6", rs_busy, 0);
    chk("post_rst_hold", hold_wb, 0);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
